// File: rtl/pipeline_sequencer.sv
// pipeline_sequencer: run controller owning the PC, IF/ID write/flush, load-use bubbles and drain/done sequencing.
module pipeline_sequencer #(
  parameter int PC_WIDTH     = 32,
  parameter int PROG_END     = 24,
  parameter int DRAIN_CYCLES = 4,
  parameter int STALL_CNT_W  = 16
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_start,
  input  logic [31:0]            i_instr,
  input  logic                   i_branch_taken,
  input  logic [31:0]            i_branch_offset,
  input  logic                   i_idex_memread,
  input  logic [4:0]             i_idex_rt,
  output logic [PC_WIDTH-1:0]    o_pc,
  output logic                   o_ifid_write,
  output logic                   o_ifid_flush,
  output logic                   o_idex_bubble,
  output logic                   o_busy,
  output logic                   o_done,
  output logic [STALL_CNT_W-1:0] o_stall_count
);
  localparam int DW = $clog2(DRAIN_CYCLES + 1);
  localparam logic [PC_WIDTH-1:0] END_PC = PC_WIDTH'(PROG_END);
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;
  state_t r_state, w_state_nx;
  logic [PC_WIDTH-1:0] r_pc, r_ifid_pc, w_pc_nx, w_target, w_seq;
  logic [DW-1:0] r_drain_cnt, w_drain_nx;
  logic [STALL_CNT_W-1:0] r_stall_cnt;
  logic r_flush_q, r_busy, r_done;
  logic w_active, w_hazard, w_take;
  assign w_active = (r_state == S_RUN) | (r_state == S_DRAIN);
  assign w_hazard = w_active & i_idex_memread & (i_idex_rt != 5'd0) &
                    ((i_idex_rt == i_instr[25:21]) | (i_idex_rt == i_instr[20:16]));
  // r_flush_q marks that IF/ID currently holds a flushed NOP, so its branch fields are stale
  assign w_take   = w_active & (i_instr[31:26] == 6'h04) & i_branch_taken & ~r_flush_q;
  assign w_target = r_ifid_pc + PC_WIDTH'(4) + PC_WIDTH'(i_branch_offset);
  assign w_seq    = r_pc + PC_WIDTH'(4);
  always_comb begin
    w_state_nx    = r_state;
    w_pc_nx       = r_pc;
    w_drain_nx    = r_drain_cnt;
    o_ifid_write  = 1'b0;
    o_ifid_flush  = 1'b0;
    o_idex_bubble = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_pc_nx    = '0;
          w_state_nx = S_RUN;
        end
      end
      S_RUN: begin
        o_idex_bubble = w_hazard;
        if (!w_hazard) begin
          o_ifid_write = 1'b1;
          o_ifid_flush = w_take;
          w_pc_nx      = w_take ? w_target : w_seq;
          if (w_pc_nx > END_PC) begin
            w_state_nx = S_DRAIN;
            w_drain_nx = DW'(DRAIN_CYCLES);
          end
        end
      end
      S_DRAIN: begin
        o_ifid_flush  = 1'b1;
        o_idex_bubble = w_hazard;
        if (!w_hazard) begin
          o_ifid_write = 1'b1;
          if (w_take && w_target <= END_PC) begin
            w_pc_nx    = w_target;
            w_state_nx = S_RUN;
          end else begin
            w_drain_nx = r_drain_cnt - DW'(1);
            w_state_nx = (r_drain_cnt == DW'(1)) ? S_DONE : S_DRAIN;
          end
        end
      end
      default: w_state_nx = S_IDLE;
    endcase
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= S_IDLE;
      r_pc        <= '0;
      r_ifid_pc   <= '0;
      r_drain_cnt <= '0;
      r_stall_cnt <= '0;
      r_flush_q   <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state_nx;
      r_pc        <= w_pc_nx;
      r_drain_cnt <= w_drain_nx;
      r_flush_q   <= o_ifid_flush;
      r_busy      <= (w_state_nx == S_RUN) | (w_state_nx == S_DRAIN);
      r_done      <= (r_state == S_DRAIN) & (w_state_nx == S_DONE);
      if (o_ifid_write) r_ifid_pc <= r_pc;
      if (r_state == S_IDLE && i_start) r_stall_cnt <= '0;
      else if (w_hazard && !(&r_stall_cnt)) r_stall_cnt <= r_stall_cnt + STALL_CNT_W'(1);
    end
  end
  assign o_pc          = r_pc;
  assign o_busy        = r_busy;
  assign o_done        = r_done;
  assign o_stall_count = r_stall_cnt;
endmodule

// File: tb/tb_pipeline_sequencer.sv
// tb_pipeline_sequencer: directed vectors with hand-computed PC, hazard, branch and drain expectations.
module tb_pipeline_sequencer;
  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic [31:0] instr = '0;
  logic        taken = 1'b0;
  logic [31:0] offset = '0;
  logic        memread = 1'b0;
  logic [4:0]  idex_rt = '0;
  logic [31:0] pc;
  logic        ifid_write, ifid_flush, idex_bubble, busy, done;
  logic [15:0] stall_count;
  int n_checks = 0;
  int n_errors = 0;
  pipeline_sequencer dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_instr(instr),
    .i_branch_taken(taken), .i_branch_offset(offset), .i_idex_memread(memread),
    .i_idex_rt(idex_rt), .o_pc(pc), .o_ifid_write(ifid_write), .o_ifid_flush(ifid_flush),
    .o_idex_bubble(idex_bubble), .o_busy(busy), .o_done(done), .o_stall_count(stall_count)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic clear_in();
    instr = '0; taken = 1'b0; offset = '0; memread = 1'b0; idex_rt = '0; start = 1'b0;
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    chk("rst_pc", pc, 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_stall", 32'(stall_count), 0);
    chk("rst_comb", {29'd0, ifid_write, ifid_flush, idex_bubble}, 0);
    rst_n = 1'b1;
  endtask
  task automatic run_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask
  initial begin
    #1;
    do_reset();
    tick();
    // straight line: pc 0..28, four drain cycles, single done pulse
    run_start();
    chk("t1_pc0", pc, 0);
    chk("t1_busy", 32'(busy), 1);
    chk("t1_write", 32'(ifid_write), 1);
    for (int k = 1; k <= 7; k++) begin
      tick();
      chk("t1_pc", pc, 32'(4 * k));
    end
    chk("t1_drain_flush", 32'(ifid_flush), 1);
    chk("t1_drain_busy", 32'(busy), 1);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("t1_drain_nodone", {30'd0, busy, done}, 32'h2);
      chk("t1_drain_pc", pc, 28);
    end
    tick();
    chk("t1_done", {30'd0, busy, done}, 32'h1);
    tick();
    chk("t1_done_pulse", {30'd0, busy, done}, 0);
    chk("t1_idle_write", 32'(ifid_write), 0);
    // load-use hazard on rs, then rt==0 no stall, then hazard on rt field
    do_reset();
    run_start();
    tick();
    memread = 1'b1; idex_rt = 5'd5; instr = 32'h00A0_0000;
    #1;
    chk("t2_bubble", 32'(idex_bubble), 1);
    chk("t2_write", 32'(ifid_write), 0);
    tick();
    chk("t2_pc_held", pc, 4);
    chk("t2_stall", 32'(stall_count), 1);
    clear_in();
    tick();
    chk("t2_resume", pc, 8);
    memread = 1'b1; idex_rt = 5'd0; instr = 32'h0;
    #1;
    chk("t2_rt0_bubble", 32'(idex_bubble), 0);
    tick();
    chk("t2_rt0_pc", pc, 12);
    chk("t2_rt0_stall", 32'(stall_count), 1);
    idex_rt = 5'd7; instr = 32'h0007_0000;
    #1;
    chk("t2_rtf_bubble", 32'(idex_bubble), 1);
    tick();
    chk("t2_rtf_pc", pc, 12);
    chk("t2_rtf_stall", 32'(stall_count), 2);
    clear_in();
    // taken beq in IF/ID at address 0, offset 0x10 -> 0x14; stale branch behind flush ignored
    do_reset();
    run_start();
    tick();
    instr = 32'h1000_0000; taken = 1'b1; offset = 32'h10;
    #1;
    chk("t3_flush", 32'(ifid_flush), 1);
    tick();
    chk("t3_target", pc, 32'h14);
    chk("t3_flush_once", 32'(ifid_flush), 0);
    tick();
    chk("t3_no_retake", pc, 32'h18);
    chk("t3_stall_start", 32'(stall_count), 0);
    // hazard and take together: stall first, then redirect to 0x14+4-0x14 = 4
    memread = 1'b1; idex_rt = 5'd5; instr = 32'h10A0_0000; taken = 1'b1; offset = 32'hFFFF_FFEC;
    #1;
    chk("t4_bubble", 32'(idex_bubble), 1);
    chk("t4_noflush", 32'(ifid_flush), 0);
    tick();
    chk("t4_pc_held", pc, 32'h18);
    chk("t4_stall", 32'(stall_count), 1);
    memread = 1'b0;
    #1;
    chk("t4_flush", 32'(ifid_flush), 1);
    tick();
    chk("t4_redirect", pc, 4);
    clear_in();
    // branch on first drain cycle, IF/ID at 24, offset -24 -> back to RUN at 4
    for (int k = 0; k < 6; k++) tick();
    chk("t5_drain_pc", pc, 28);
    instr = 32'h1000_0000; taken = 1'b1; offset = 32'hFFFF_FFE8;
    tick();
    chk("t5_back_pc", pc, 4);
    chk("t5_back_state", {30'd0, busy, done}, 32'h2);
    chk("t5_back_flush", 32'(ifid_flush), 0);
    clear_in();
    for (int k = 0; k < 6; k++) tick();
    chk("t5_redrain", pc, 28);
    tick();
    instr = 32'h1000_0000; taken = 1'b1; offset = 32'hFFFF_FFE8;
    tick();
    chk("t5_late_take", pc, 28);
    clear_in();
    tick();
    chk("t5_late_nodone", 32'(done), 0);
    tick();
    chk("t5_done", {30'd0, busy, done}, 32'h1);
    // start during RUN is ignored; async reset mid-drain clears everything with no edge
    do_reset();
    run_start();
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("t6_start_ign", pc, 8);
    for (int k = 0; k < 5; k++) tick();
    tick();
    chk("t6_in_drain", {30'd0, busy, done}, 32'h2);
    do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    chk("t6_no_done", {30'd0, busy, done}, 0);
    rst_n = 1'b1;
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
